// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core: register-file geometry,
// data width and the hard-wired zero register address.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // A write only takes effect when enabled and not aimed at the zero register.
    function automatic logic wr_commit(input logic                  we,
                                       input logic [REG_ADDR_W-1:0] addr);
        return we && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One read port of the register file: zero-register masking, optional
// write-data bypass and selection from the storage view.
module reg_read_port
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [REG_ADDR_W-1:0] addr_i,
    input  logic                  bypass_en_i,
    input  logic                  wr_commit_i,
    input  logic [REG_ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic [WIDTH-1:0]      regs_i [NUM_REGS],
    output logic [WIDTH-1:0]      rd_data_o
);

    always_comb begin
        rd_data_o = '0;
        if (addr_i != REG_ZERO) begin
            if (bypass_en_i && wr_commit_i && (addr_i == wr_addr_i)) begin
                rd_data_o = wr_data_i;
            end else begin
                rd_data_o = regs_i[addr_i];
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32 x WIDTH register file: two combinational read ports with optional bypass,
// one synchronous write port, a registered debug read port and a write counter.
module reg_file
    import cpu_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] WriteReg,
    input  logic [WIDTH-1:0]      WriteData,
    output logic [WIDTH-1:0]      ReadData1,
    output logic [WIDTH-1:0]      ReadData2,
    input  logic [REG_ADDR_W-1:0] DbgAddr,
    output logic [WIDTH-1:0]      DbgData,
    output logic [CNT_W-1:0]      WriteCount
);

    logic                 commit;
    logic                 bypass_en;
    logic [WIDTH-1:0]     regs_q  [1:NUM_REGS-1];
    logic [WIDTH-1:0]     rf_view [NUM_REGS];
    logic [WIDTH-1:0]     dbg_sel;
    logic [WIDTH-1:0]     dbg_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    assign commit = wr_commit(RegWrite, WriteReg);
    // Bypass is gated by reset so every read port shows 0 while rst_n is low.
    assign bypass_en = (BYPASS != 0) && rst_n;

    assign rf_view[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[gi] <= '0;
                end else if (commit && (WriteReg == REG_ADDR_W'(gi))) begin
                    regs_q[gi] <= WriteData;
                end
            end
            assign rf_view[gi] = regs_q[gi];
        end
    endgenerate

    reg_read_port #(.WIDTH(WIDTH)) u_port1 (
        .addr_i      (rs),
        .bypass_en_i (bypass_en),
        .wr_commit_i (commit),
        .wr_addr_i   (WriteReg),
        .wr_data_i   (WriteData),
        .regs_i      (rf_view),
        .rd_data_o   (ReadData1)
    );

    reg_read_port #(.WIDTH(WIDTH)) u_port2 (
        .addr_i      (rt),
        .bypass_en_i (bypass_en),
        .wr_commit_i (commit),
        .wr_addr_i   (WriteReg),
        .wr_data_i   (WriteData),
        .regs_i      (rf_view),
        .rd_data_o   (ReadData2)
    );

    // Debug port samples pre-write storage, so it never bypasses.
    reg_read_port #(.WIDTH(WIDTH)) u_dbg (
        .addr_i      (DbgAddr),
        .bypass_en_i (1'b0),
        .wr_commit_i (commit),
        .wr_addr_i   (WriteReg),
        .wr_data_i   (WriteData),
        .regs_i      (rf_view),
        .rd_data_o   (dbg_sel)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (commit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_q <= '0;
            cnt_q <= '0;
        end else begin
            dbg_q <= dbg_sel;
            cnt_q <= cnt_d;
        end
    end

    assign DbgData    = dbg_q;
    assign WriteCount = cnt_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one bypassing 16-bit-counter instance and one
// non-bypassing 4-bit-counter instance driven by the same stimulus.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  rs, rt, WriteReg, DbgAddr;
    logic [31:0] WriteData;

    logic [31:0] rd1_a, rd2_a, dbg_a;
    logic [15:0] wc_a;
    logic [31:0] rd1_b, rd2_b, dbg_b;
    logic [3:0]  wc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file #(.WIDTH(32), .BYPASS(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .rs(rs), .rt(rt),
        .WriteReg(WriteReg), .WriteData(WriteData), .ReadData1(rd1_a),
        .ReadData2(rd2_a), .DbgAddr(DbgAddr), .DbgData(dbg_a), .WriteCount(wc_a)
    );

    reg_file #(.WIDTH(32), .BYPASS(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .rs(rs), .rt(rt),
        .WriteReg(WriteReg), .WriteData(WriteData), .ReadData1(rd1_b),
        .ReadData2(rd2_b), .DbgAddr(DbgAddr), .DbgData(dbg_b), .WriteCount(wc_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        RegWrite  = 1'b1;
        WriteReg  = a;
        WriteData = d;
        tick();
        RegWrite  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; RegWrite = 1'b0; rs = '0; rt = '0;
        WriteReg = '0; WriteData = '0; DbgAddr = '0;

        // Reset held: every address reads 0
        #2;
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(31 - i); #1;
            check_val($sformatf("rst_rd1_a[%0d]", i), rd1_a, 32'h0);
            check_val($sformatf("rst_rd2_b[%0d]", 31 - i), rd2_b, 32'h0);
        end
        check_val("rst_dbg_a", dbg_a, 32'h0);
        check_val("rst_wc_a", {16'h0, wc_a}, 32'h0);
        check_val("rst_wc_b", {28'h0, wc_b}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i += 8) begin
            DbgAddr = 5'(i);
            tick();
            check_val($sformatf("post_rst_dbg[%0d]", i), dbg_a, 32'h0);
        end
        check_val("post_rst_wc_a", {16'h0, wc_a}, 32'h0);

        // Fill registers 1..31 and read back
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(i); #1;
            check_val($sformatf("rb_rd1_a[%0d]", i), rd1_a, (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i));
            check_val($sformatf("rb_rd2_b[%0d]", i), rd2_b, (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i));
        end
        check_val("fill_wc_a", {16'h0, wc_a}, 32'd31);
        check_val("fill_wc_b", {28'h0, wc_b}, 32'd15);

        // Register 0 writes are discarded and never bypassed
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFF_FFFF;
        rs = 5'd0; rt = 5'd0; DbgAddr = 5'd0; #1;
        check_val("r0_bypass_rd1_a", rd1_a, 32'h0);
        check_val("r0_bypass_rd2_a", rd2_a, 32'h0);
        tick();
        RegWrite = 1'b0; #1;
        check_val("r0_rd1_a", rd1_a, 32'h0);
        check_val("r0_dbg_a", dbg_a, 32'h0);
        check_val("r0_wc_a", {16'h0, wc_a}, 32'd31);

        // Bypass vs. stored value
        wr(5'd5, 32'h1111_1111);
        RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h2222_2222;
        rs = 5'd5; rt = 5'd5; #1;
        check_val("byp_rd1_a", rd1_a, 32'h2222_2222);
        check_val("byp_rd2_a", rd2_a, 32'h2222_2222);
        check_val("nobyp_rd1_b", rd1_b, 32'h1111_1111);
        check_val("nobyp_rd2_b", rd2_b, 32'h1111_1111);
        tick();
        RegWrite = 1'b0; #1;
        check_val("nobyp_next_rd1_b", rd1_b, 32'h2222_2222);
        check_val("nobyp_next_rd2_b", rd2_b, 32'h2222_2222);
        check_val("byp_wc_a", {16'h0, wc_a}, 32'd33);
        check_val("byp_wc_b", {28'h0, wc_b}, 32'd1);

        // Debug read-before-write
        wr(5'd7, 32'h3);
        DbgAddr = 5'd7;
        RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h4;
        tick();
        RegWrite = 1'b0;
        check_val("dbg_old_a", dbg_a, 32'h3);
        check_val("dbg_old_b", dbg_b, 32'h3);
        tick();
        check_val("dbg_new_a", dbg_a, 32'h4);

        // Asynchronous reset mid-cycle with a pending write
        RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'hDEAD_BEEF;
        rs = 5'd7; rt = 5'd9; #2;
        check_val("pre_rst_byp_rd2_a", rd2_a, 32'hDEAD_BEEF);
        rst_n = 1'b0; #1;
        check_val("arst_rd1_a", rd1_a, 32'h0);
        check_val("arst_rd2_a", rd2_a, 32'h0);
        check_val("arst_dbg_a", dbg_a, 32'h0);
        check_val("arst_wc_a", {16'h0, wc_a}, 32'h0);
        check_val("arst_wc_b", {28'h0, wc_b}, 32'h0);
        tick();
        RegWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; #1;
        check_val("arst_lost_wr_rd2_a", rd2_a, 32'h0);
        check_val("arst_lost_wr_rd2_b", rd2_b, 32'h0);

        // 17 writes: 4-bit counter wraps to 1
        for (int k = 0; k < 17; k++) wr(5'(1 + (k % 31)), 32'(k));
        check_val("wrap_wc_a", {16'h0, wc_a}, 32'd17);
        check_val("wrap_wc_b", {28'h0, wc_b}, 32'd1);
        rs = 5'd17; rt = 5'd1; #1;
        check_val("wrap_rd1_a", rd1_a, 32'd16);
        check_val("wrap_rd2_a", rd2_a, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

General-purpose register file of the single-cycle MIPS core: 32 × 32-bit registers, two combinational read ports and one synchronous write port. It sits directly downstream of the destination-register select mux. That mux supplies `WriteReg`, rd or rt chosen by `RegDst`. The block feeds `ReadData1` and `ReadData2` to the ALU operand path. A debug read port and a write counter support bench and board-level inspection.

## Interface
Parameters:
- `WIDTH`, 32: data width of each register.
- `BYPASS`, 1: 1 means a read of the register being written this cycle returns `WriteData`. 0 means it returns the stored value.
- `CNT_W`, 16: width of the write counter.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `RegWrite`  in  1  write enable from control.
- `rs`  in  5  read address, port 1.
- `rt`  in  5  read address, port 2.
- `WriteReg`  in  5  write address (output of RegDst mux).
- `WriteData`  in  WIDTH  write data.
- `ReadData1`  out  WIDTH  contents of `rs`.
- `ReadData2`  out  WIDTH  contents of `rt`.
- `DbgAddr`  in  5  debug read address.
- `DbgData`  out  WIDTH  contents of `DbgAddr`, registered.
- `WriteCount`  out  CNT_W  number of committed writes since reset.

## Operation
- Storage is registers 1..31. Register 0 is not stored.
  - Reads of address 0 return 0 on every port.
  - Writes to address 0 are discarded and do not increment `WriteCount`.
- Write: on a rising edge with `RegWrite`=1 and `WriteReg`≠0, register `WriteReg` takes `WriteData`.
- Read ports 1/2 are combinational from `rs`/`rt`.
- Bypass, when `BYPASS`=1 and all of the following hold: `RegWrite`=1, `WriteReg`≠0 and the read address equals `WriteReg`.
  - The port outputs `WriteData` combinationally.
  - Otherwise the port outputs the stored value.
- `DbgData` is registered. On each rising edge it takes the value of register `DbgAddr` as stored before that edge's write, with no bypass. `DbgAddr`=0 gives 0.
- `WriteCount` increments by 1 on every committed write (`RegWrite`=1, `WriteReg`≠0). It wraps from 2^CNT_W−1 to 0.
- Reset (`rst_n`=0, asynchronous):
  - Registers 1..31 go to 0.
  - `DbgData` goes to 0.
  - `WriteCount` goes to 0.
  - `ReadData1`/`ReadData2` therefore read 0 for all addresses while reset is held. Bypass is suppressed during reset.
  - A write in progress when reset asserts is lost.
- Deassertion of `rst_n` is synchronised externally. The first write can commit on the first rising edge with `rst_n`=1.

## Timing
- Read ports: zero-cycle latency, combinational from address and storage (and from `WriteData` when bypassing).
- Write: committed at the rising edge. A read in the following cycle returns the new value regardless of `BYPASS`.
- Debug port: one-cycle latency.
- Simultaneous events:
  - `rs`=`rt`=`WriteReg` with `RegWrite`=1: both ports obey the same bypass rule.
  - Write and debug read of the same address on the same edge: `DbgData` gets the old value.
- No handshake. A write is accepted on every enabled cycle and there is no stall.
- Reset values:
  - `DbgData`=0, `WriteCount`=0.
  - `ReadData1`/`ReadData2`=0, since all storage is 0.

## Structure
- Shared package `cpu_pkg` holds:
  - `REG_ADDR_W`=5 and `NUM_REGS`=32.
  - `DATA_W`=32.
  - `REG_ZERO`=5'd0, used by the mux, control and this block.
- One sub-module is natural: `reg_read_port`. It covers address-0 masking, bypass compare and the storage select, and is instantiated twice for ports 1 and 2.
- The debug port reuses the same select logic with bypass disabled.
- Storage array and counter stay in the top module.

## Test plan
- Reset then read: hold `rst_n`=0, then release. Sweep `rs`/`rt`/`DbgAddr` over 0..31 → all outputs 0, `WriteCount`=0.
- Write/readback: write 0xA5A5_0000+i to register i for i=1..31, then read them back on both ports → exact values, `WriteCount`=31.
- Register 0:
  - Write 0xFFFF_FFFF to address 0 → `ReadData1`(rs=0)=0 and `DbgData`=0.
  - `WriteCount` unchanged.
  - No bypass, even with `rs`=0 during the write.
- Bypass, `BYPASS`=1: register 5 holds 0x1111_1111. Drive `RegWrite`=1, `WriteReg`=5, `WriteData`=0x2222_2222, `rs`=`rt`=5 → both ports read 0x2222_2222 in the same cycle. With `BYPASS`=0 they read 0x1111_1111 that cycle and 0x2222_2222 the next.
- Debug read-before-write: `DbgAddr`=7 with register 7=0x3; write 0x4 to register 7 → `DbgData`=0x3 after that edge and 0x4 one edge later.
- Reset mid-operation and counter wrap:
  - Assert `rst_n`=0 asynchronously between edges while `RegWrite`=1 → `ReadData`/`DbgData`/`WriteCount` go to 0 immediately, and the pending write is not committed.
  - With `CNT_W`=4, commit 17 writes → `WriteCount`=1.
